// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
package fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundles the instruction-memory, redirect and decode handshakes of the fetch unit.
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_ready;

    modport master (
        output imem_req, imem_addr, id_valid, id_pc, id_inst,
        input  imem_ack, imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_pc, id_inst,
        output imem_ack, imem_rdata, redirect_valid, redirect_pc, id_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode: synchronous push/pop/flush with occupancy count.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wdata,
    output fetch_entry_t     rdata,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        // NOTE: every signal is given a default first so no path can infer a latch.
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = ptr_next(rd_ptr_q);
            if (do_push) wr_ptr_d = ptr_next(wr_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so each samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, redirect handling, buffered hand-off to decode.
// Defining FETCH_PERF_CNT_EN adds delivered-instruction and stall-cycle counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  perf_fetch_cnt,
    output logic [31:0]  perf_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      addr_q, addr_d;
    logic             run_q;
    logic [CNT_W-1:0] count;
    fetch_entry_t     head;
    fetch_entry_t     wdata;
    logic             push, pop, flush, id_valid;
    logic [31:0]      redirect_tgt;

    assign redirect_tgt = word_align(bus.redirect_pc);
    assign id_valid     = (count != '0);
    assign pop          = id_valid && bus.id_ready;
    assign wdata        = '{pc: pc_q, inst: bus.imem_rdata};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        addr_d        = addr_q;
        push          = 1'b0;
        flush         = 1'b0;
        bus.imem_req  = 1'b0;
        bus.imem_addr = pc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = redirect_tgt;
                end else if (run_q && (count < CNT_W'(FIFO_DEPTH))) begin
                    bus.imem_req = 1'b1;
                    if (bus.imem_ack) begin
                        push = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end else begin
                        addr_d  = pc_q;
                        state_d = ST_WAIT;
                    end
                end
            end
            // The address is held from addr_q because PC may already point at a redirect target.
            ST_WAIT: begin
                bus.imem_req  = 1'b1;
                bus.imem_addr = addr_q;
                if (bus.redirect_valid) begin
                    flush   = 1'b1;
                    pc_d    = redirect_tgt;
                    state_d = bus.imem_ack ? ST_IDLE : ST_DROP;
                end else if (bus.imem_ack) begin
                    push    = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                bus.imem_req  = 1'b1;
                bus.imem_addr = addr_q;
                if (bus.redirect_valid) pc_d = redirect_tgt;
                if (bus.imem_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= word_align(RESET_PC);
            addr_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            run_q   <= 1'b1;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wdata),
        .rdata (head),
        .count (count)
    );

    assign bus.id_valid = id_valid;
    assign bus.id_pc    = id_valid ? head.pc : 32'h0000_0000;
    assign bus.id_inst  = id_valid ? head.inst : NOP_INST;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q + 32'(pop);
        perf_stall_d = perf_stall_q + 32'(!pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a
// transaction-level model (outstanding-request flag, PC, and a queue standing in for the buffer).
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fetch_unit_if bus();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    bit          m_busy;
    bit          m_drop;
    bit          m_run;
    logic [31:0] m_fetch;
    logic [31:0] m_stall;

    task automatic model_reset();
        mq.delete();
        m_pc    = RST_PC & 32'hFFFF_FFFC;
        m_addr  = '0;
        m_busy  = 1'b0;
        m_drop  = 1'b0;
        m_run   = 1'b0;
        m_fetch = '0;
        m_stall = '0;
    endtask

    // Compare on the falling edge, then advance the model to what the next rising edge must produce.
    always @(negedge clk) begin
        logic        exp_req, exp_valid;
        logic [31:0] exp_addr, tgt;
        if (!rst) begin
            check("rst_imem_req", bus.imem_req, 1'b0);
            check("rst_id_valid", bus.id_valid, 1'b0);
            check("rst_id_pc", bus.id_pc, 32'h0);
            check("rst_id_inst", bus.id_inst, 32'h0000_0013);
            model_reset();
        end else begin
            exp_valid = (mq.size() != 0);
            if (m_busy) begin
                exp_req  = 1'b1;
                exp_addr = m_addr;
            end else begin
                exp_req  = m_run && !bus.redirect_valid && (mq.size() < DEPTH);
                exp_addr = m_pc;
            end
            check("imem_req", bus.imem_req, exp_req);
            if (exp_req) check("imem_addr", bus.imem_addr, exp_addr);
            check("id_valid", bus.id_valid, exp_valid);
            if (exp_valid) begin
                check("id_pc", bus.id_pc, mq[0].pc);
                check("id_inst", bus.id_inst, mq[0].inst);
            end
`ifdef FETCH_PERF_CNT_EN
            check("perf_fetch", perf_fetch_cnt, m_fetch);
            check("perf_stall", perf_stall_cnt, m_stall);
            if (exp_valid && bus.id_ready) m_fetch = m_fetch + 1;
            else m_stall = m_stall + 1;
`endif
            tgt = bus.redirect_pc & 32'hFFFF_FFFC;
            if (bus.redirect_valid) begin
                mq.delete();
                m_pc = tgt;
                if (m_busy && !bus.imem_ack) begin
                    m_drop = 1'b1;
                end else begin
                    m_busy = 1'b0;
                    m_drop = 1'b0;
                end
            end else begin
                if (exp_valid && bus.id_ready) void'(mq.pop_front());
                if (exp_req && bus.imem_ack) begin
                    if (!m_drop) begin
                        mq.push_back('{pc: exp_addr, inst: bus.imem_rdata});
                        m_pc = exp_addr + 32'd4;
                    end
                    m_busy = 1'b0;
                    m_drop = 1'b0;
                end else if (exp_req) begin
                    m_busy = 1'b1;
                    m_addr = exp_addr;
                end
            end
            m_run = 1'b1;
        end
    end

    task automatic drive(input logic ack, input logic rdy, input logic redir, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        bus.imem_ack       = ack;
        bus.id_ready       = rdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.imem_rdata     = $urandom;
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst                = 1'b0;
        bus.imem_ack       = 1'b0;
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("post_release_req", bus.imem_req, 1'b0);
    endtask

    initial begin
        int ack_pct;
        logic [31:0] rpc;
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b0;

        // Streaming with ack tied high: one instruction per cycle.
        do_reset();
        drive(1, 1, 0, 0); check("s1_addr0", bus.imem_addr, 32'h0); check("s1_req", bus.imem_req, 1'b1);
        drive(1, 1, 0, 0); check("s1_addr4", bus.imem_addr, 32'h4); check("s1_pc0", bus.id_pc, 32'h0);
        drive(1, 1, 0, 0); check("s1_addr8", bus.imem_addr, 32'h8); check("s1_pc4", bus.id_pc, 32'h4);
        drive(1, 1, 0, 0); check("s1_pc8", bus.id_pc, 32'h8);

        // Decode stall: buffer fills to depth and requests stop.
        do_reset();
        repeat (5) drive(1, 0, 0, 0);
        check("s2_req_full", bus.imem_req, 1'b0); check("s2_head", bus.id_pc, 32'h0);
        drive(1, 1, 0, 0); check("s2_resume0", bus.id_pc, 32'h0); check("s2_req_still", bus.imem_req, 1'b0);
        drive(1, 1, 0, 0); check("s2_resume4", bus.id_pc, 32'h4); check("s2_addr8", bus.imem_addr, 32'h8);
        drive(1, 1, 0, 0); check("s2_resume8", bus.id_pc, 32'h8);

        // Redirect during WAIT, ack three cycles later: stale response dropped.
        do_reset();
        drive(0, 1, 0, 0);
        drive(0, 1, 1, 32'h100); check("s3_held", bus.imem_addr, 32'h0);
        drive(0, 1, 0, 0);       check("s3_drop_req", bus.imem_req, 1'b1);
        drive(0, 1, 0, 0);
        drive(1, 1, 0, 0);       check("s3_drop_addr", bus.imem_addr, 32'h0);
        drive(1, 1, 0, 0);       check("s3_new_addr", bus.imem_addr, 32'h100); check("s3_no_stale", bus.id_valid, 1'b0);
        drive(1, 1, 0, 0);       check("s3_first_pc", bus.id_pc, 32'h100);

        // Redirect coincident with ack (in WAIT), then redirect in IDLE, then PC wrap.
        do_reset();
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);       check("s4_wait_addr", bus.imem_addr, 32'h4);
        drive(1, 1, 1, 32'h203); check("s4_req", bus.imem_req, 1'b1);
        drive(1, 0, 0, 0);       check("s4_flushed", bus.id_valid, 1'b0); check("s4_addr200", bus.imem_addr, 32'h200);
        drive(1, 0, 1, 32'h40);  check("s4_idle_redir_req", bus.imem_req, 1'b0); check("s4_pc200", bus.id_pc, 32'h200);
        drive(1, 1, 0, 0);       check("s4_flush2", bus.id_valid, 1'b0); check("s4_addr40", bus.imem_addr, 32'h40);
        drive(1, 1, 1, 32'hFFFF_FFFF);
        drive(1, 1, 0, 0);       check("s5_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
        drive(1, 1, 0, 0);       check("s5_wrap", bus.imem_addr, 32'h0); check("s5_pc_top", bus.id_pc, 32'hFFFF_FFFC);
        drive(1, 1, 0, 0);       check("s5_pc_wrap", bus.id_pc, 32'h0);

        // Reset asserted mid-WAIT.
        do_reset();
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);       check("s6_wait", bus.imem_addr, 32'h4);
        rst = 1'b0;
        #1;
        check("s6_req", bus.imem_req, 1'b0); check("s6_valid", bus.id_valid, 1'b0);
        check("s6_pc", bus.id_pc, 32'h0);    check("s6_inst", bus.id_inst, 32'h0000_0013);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1, 1, 0, 0);       check("s6_restart", bus.imem_addr, RST_PC); check("s6_restart_req", bus.imem_req, 1'b1);

        // Randomized traffic; ack rate alternates between epochs.
        for (int i = 0; i < 4000; i++) begin
            ack_pct = ((i / 500) % 2 == 0) ? 40 : 90;
            if ($urandom_range(0, 999) < 3) do_reset();
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            drive($urandom_range(0, 99) < ack_pct, $urandom_range(0, 99) < 70,
                  $urandom_range(0, 99) < 6, rpc);
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: instruction buffer entries (legal 2..8).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  word-aligned fetch address.
REQ-007 imem_ack  input  1  request accepted; imem_rdata valid this cycle.
REQ-008 imem_rdata  input  32  fetched instruction.
REQ-009 redirect_valid  input  1  branch/jump/trap redirect from EX/MEM.
REQ-010 redirect_pc  input  32  redirect target.
REQ-011 id_valid  output  1  head buffer entry valid for IF_ID.
REQ-012 id_pc  output  32  PC of head entry.
REQ-013 id_inst  output  32  instruction of head entry.
REQ-014 id_ready  input  1  decode accepts head (low = hazard stall).

Function
REQ-015 SHALL keep the fetch PC register; imem_addr = {pc[31:2], 2'b00}.
REQ-016 SHALL implement FSM IDLE, WAIT, DROP; at most one outstanding request.
REQ-017 IDLE: assert imem_req when buffer occupancy < FIFO_DEPTH and no redirect; imem_ack same cycle pushes, PC += 4, stays IDLE; no ack -> WAIT.
REQ-018 WAIT: imem_req and imem_addr SHALL stay stable until imem_ack; ack pushes {pc, imem_rdata}, PC += 4, -> IDLE.
REQ-019 Redirect in WAIT without ack: PC <= redirect_pc, buffer flushed, -> DROP; request held stable.
REQ-020 DROP: imem_req/imem_addr held until imem_ack; response discarded, no push, -> IDLE; further redirects in DROP update PC only.
REQ-021 Redirect in IDLE, or coincident with imem_ack: response discarded, buffer flushed, PC <= redirect_pc, -> IDLE; imem_req SHALL be low in the redirect cycle when IDLE.
REQ-022 redirect_pc[1:0] SHALL be ignored (forced 0).
REQ-023 PC increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-024 id_valid = buffer non-empty; id_pc/id_inst = head entry; pop on id_valid & id_ready.
REQ-025 Redirect SHALL win over pop: id_valid low the cycle after redirect.
REQ-026 Simultaneous push and pop when full SHALL be legal; occupancy unchanged.
REQ-027 Throughput SHALL be one instruction/cycle when imem_ack returns in the request cycle and id_ready high; latency imem_ack -> id_valid = 1 cycle.

Reset
REQ-028 On rst low: PC = RESET_PC, FSM = IDLE, buffer empty, imem_req = 0, id_valid = 0, id_pc = 0, id_inst = 32'h0000_0013 (NOP).
REQ-029 Reset asserted mid-WAIT SHALL abandon the request; memory side tolerates withdrawal under reset.
REQ-030 First imem_req SHALL rise in the first clock edge after rst release.

Configuration
REQ-031 Macro FETCH_PERF_CNT_EN: when defined, adds outputs perf_fetch_cnt (32, instructions delivered to decode) and perf_stall_cnt (32, cycles with id_valid=0 or id_ready=0), both reset to 0, wrapping; when undefined, the ports and counters SHALL not exist.

Structure
REQ-032 Shared package SHALL hold the FSM state enum, NOP constant 32'h0000_0013, and default RESET_PC.
REQ-033 Buffer SHALL be sub-module fetch_fifo (synchronous push/pop/flush, count output).

Verification
REQ-034 Reset release, imem_ack tied high, id_ready high -> imem_addr 0,4,8,...; id_pc 0,4,8 on consecutive cycles.
REQ-035 id_ready low 5 cycles, FIFO_DEPTH 2 -> exactly 2 entries buffered, imem_req low, no instruction lost or duplicated on resume.
REQ-036 Redirect to 32'h100 during WAIT, ack 3 cycles later -> stale data dropped, next imem_addr 32'h100, first id_pc 32'h100.
REQ-037 Redirect to 32'h203 coincident with imem_ack and id_ready -> buffer flushed, next imem_addr 32'h200.
REQ-038 PC at 32'hFFFF_FFFC fetched -> next imem_addr 32'h0000_0000.
REQ-039 rst asserted mid-WAIT -> outputs reset values immediately; fetch restarts at RESET_PC.
